serial_sample_loader: RTL and testbench

Parametrised serial front end for the SGD regression core. It deserialises an LSB-first bit stream into W-bit words and stores them in an internal sample memory indexed by (data point, feature slot). It raises a completion flag once the configured number of points has been received, then serves the stored words to the gradient engine through a registered read port. It generalises the fixed 16-bit, 12-words-per-point serial load path: width, depth and point count are parameters, it adds a bit-valid qualifier, a configuration check and an optional checksum.

---
 rtl/sgd_pkg.sv | 16 +
 rtl/sample_mem.sv | 52 +++++
 rtl/serial_sample_loader.sv | 193 +++++++++++++++++++
 tb/tb_serial_sample_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD regression core: loader state encoding and the
// default sample geometry that the loader and the gradient engine agree on.
package sgd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } load_state_e;

  localparam int SGD_W          = 16;
  localparam int SGD_MAX_FEAT   = 15;
  localparam int SGD_MAX_POINTS = 64;

endpackage

// File: rtl/sample_mem.sv
// Sample memory: one write port, one registered read port, addressed by
// (point, feature slot). Out-of-range reads return zero.
module sample_mem
  import sgd_pkg::*;
#(
  parameter int W          = SGD_W,
  parameter int MAX_FEAT   = SGD_MAX_FEAT,
  parameter int MAX_POINTS = SGD_MAX_POINTS,
  parameter int PT_W       = 12
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          we,
  input  logic [PT_W-1:0]               wr_pt,
  input  logic [$clog2(MAX_FEAT+1)-1:0] wr_f,
  input  logic [W-1:0]                  wr_data,
  input  logic [PT_W-1:0]               rd_pt,
  input  logic [$clog2(MAX_FEAT+1)-1:0] rd_f,
  output logic [W-1:0]                  rd_data
);

  localparam int SLOTS = MAX_FEAT + 1;
  localparam int DEPTH = MAX_POINTS * SLOTS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_ok;

  assign wr_addr = AW'(32'(wr_pt) * SLOTS + 32'(wr_f));
  assign rd_addr = AW'(32'(rd_pt) * SLOTS + 32'(rd_f));
  assign rd_ok   = (32'(rd_pt) < MAX_POINTS) && (32'(rd_f) <= MAX_FEAT);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a same-cycle read of the slot being written sees the old word.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/serial_sample_loader.sv
// Serial front end: deserialises an LSB-first bit stream into the sample memory,
// highest feature slot first. Define SERIAL_LOADER_CHECKSUM_EN for a trailing checksum word.
module serial_sample_loader
  import sgd_pkg::*;
#(
  parameter int W          = SGD_W,
  parameter int MAX_FEAT   = SGD_MAX_FEAT,
  parameter int MAX_POINTS = SGD_MAX_POINTS,
  parameter int PT_W       = 12
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 START,
  input  logic [$clog2(MAX_FEAT+1)-1:0]        feat,
  input  logic [PT_W-1:0]                      data_points,
  input  logic                                 S,
  input  logic                                 S_VALID,
  input  logic [PT_W-1:0]                      RD_PT,
  input  logic [$clog2(MAX_FEAT+1)-1:0]        RD_F,
  output logic [W-1:0]                         RD_DATA,
  output logic                                 LOAD_BUSY,
  output logic                                 LOAD_DONE,
  output logic                                 CFG_ERR,
  output logic                                 CHK_ERR,
  output logic [PT_W+$clog2(MAX_FEAT+1)-1:0]   WORDS_LOADED
);

  localparam int FW   = $clog2(MAX_FEAT + 1);
  localparam int BW   = (W > 1) ? $clog2(W) : 1;
  localparam int WL_W = PT_W + FW;

`ifdef SERIAL_LOADER_CHECKSUM_EN
  localparam load_state_e AFTER_LOAD = CHK;
`else
  localparam load_state_e AFTER_LOAD = DONE;
`endif

  load_state_e     state_reg, state_next;
  logic [FW-1:0]   feat_reg;
  logic [PT_W-1:0] pts_reg;
  logic [BW-1:0]   bit_cnt_reg;
  logic [FW-1:0]   f_idx_reg;
  logic [PT_W-1:0] pt_reg;
  logic [W-1:0]    shift_reg;
  logic [WL_W-1:0] words_reg;
  logic            cfg_err_reg;

  logic            start_ok;
  logic            cfg_bad;
  logic            cfg_zero;
  logic            sample;
  logic            word_end;
  logic            data_word_end;
  logic            last_slot;
  logic [W-1:0]    bit_word;

  assign start_ok      = START && ((state_reg == IDLE) || (state_reg == DONE));
  assign cfg_bad       = (32'(data_points) > MAX_POINTS) || (32'(feat) > MAX_FEAT);
  assign cfg_zero      = (data_points == '0);
  assign sample        = S_VALID && ((state_reg == LOAD) || (state_reg == CHK));
  assign word_end      = sample && (bit_cnt_reg == BW'(W - 1));
  assign data_word_end = word_end && (state_reg == LOAD);
  assign last_slot     = (f_idx_reg == '0) && (pt_reg == (pts_reg - 1'b1));

  // Shift register with the current bit dropped into its slot; on the final bit
  // this is the complete word, which lets the write land on that same edge.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit_insert
    assign bit_word[gi] = (bit_cnt_reg == BW'(gi)) ? S : shift_reg[gi];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        if (START) begin
          state_next = (cfg_bad || cfg_zero) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (data_word_end && last_slot) begin
          state_next = AFTER_LOAD;
        end
      end
      CHK: begin
        if (word_end) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    LOAD_BUSY = 1'b0;
    LOAD_DONE = 1'b0;
    unique case (state_reg)
      LOAD, CHK: LOAD_BUSY = 1'b1;
      DONE:      LOAD_DONE = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      feat_reg    <= '0;
      pts_reg     <= '0;
      bit_cnt_reg <= '0;
      f_idx_reg   <= '0;
      pt_reg      <= '0;
      shift_reg   <= '0;
      words_reg   <= '0;
      cfg_err_reg <= 1'b0;
    end else if (start_ok) begin
      feat_reg    <= feat;
      pts_reg     <= data_points;
      bit_cnt_reg <= '0;
      f_idx_reg   <= feat;
      pt_reg      <= '0;
      shift_reg   <= '0;
      words_reg   <= '0;
      cfg_err_reg <= cfg_bad;
    end else if (sample) begin
      shift_reg   <= bit_word;
      bit_cnt_reg <= word_end ? '0 : bit_cnt_reg + 1'b1;
      if (data_word_end) begin
        if (f_idx_reg == '0) begin
          f_idx_reg <= feat_reg;
          pt_reg    <= pt_reg + 1'b1;
        end else begin
          f_idx_reg <= f_idx_reg - 1'b1;
        end
        if (words_reg != '1) begin
          words_reg <= words_reg + 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [W-1:0] sum_reg;
  logic         chk_err_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else if (start_ok) begin
      sum_reg     <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      if (data_word_end) begin
        sum_reg <= sum_reg + bit_word;
      end
      if (word_end && (state_reg == CHK)) begin
        chk_err_reg <= (bit_word != sum_reg);
      end
    end
  end

  assign CHK_ERR = chk_err_reg;
`else
  assign CHK_ERR = 1'b0;
`endif

  assign CFG_ERR      = cfg_err_reg;
  assign WORDS_LOADED = words_reg;

  sample_mem #(
    .W          (W),
    .MAX_FEAT   (MAX_FEAT),
    .MAX_POINTS (MAX_POINTS),
    .PT_W       (PT_W)
  ) u_mem (
    .clk     (CLK),
    .srst    (RST),
    .we      (data_word_end),
    .wr_pt   (pt_reg),
    .wr_f    (f_idx_reg),
    .wr_data (bit_word),
    .rd_pt   (RD_PT),
    .rd_f    (RD_F),
    .rd_data (RD_DATA)
  );

endmodule

// File: tb/tb_serial_sample_loader.sv
// Testbench for serial_sample_loader: random word streams checked against a
// slot-level memory model; adapts to builds with SERIAL_LOADER_CHECKSUM_EN.
module tb_serial_sample_loader;

  localparam int W          = 16;
  localparam int MAX_FEAT   = 15;
  localparam int MAX_POINTS = 64;
  localparam int PT_W       = 12;
  localparam int FW         = 4;
`ifdef SERIAL_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            START = 1'b0;
  logic [FW-1:0]   feat = '0;
  logic [PT_W-1:0] data_points = '0;
  logic            S = 1'b0;
  logic            S_VALID = 1'b0;
  logic [PT_W-1:0] RD_PT = '0;
  logic [FW-1:0]   RD_F = '0;
  logic [W-1:0]    RD_DATA;
  logic            LOAD_BUSY;
  logic            LOAD_DONE;
  logic            CFG_ERR;
  logic            CHK_ERR;
  logic [PT_W+FW-1:0] WORDS_LOADED;

  serial_sample_loader #(
    .W(W), .MAX_FEAT(MAX_FEAT), .MAX_POINTS(MAX_POINTS), .PT_W(PT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .feat(feat), .data_points(data_points),
    .S(S), .S_VALID(S_VALID), .RD_PT(RD_PT), .RD_F(RD_F), .RD_DATA(RD_DATA),
    .LOAD_BUSY(LOAD_BUSY), .LOAD_DONE(LOAD_DONE), .CFG_ERR(CFG_ERR),
    .CHK_ERR(CHK_ERR), .WORDS_LOADED(WORDS_LOADED)
  );

  always #5 CLK = ~CLK;

  int edges = 0;
  always @(posedge CLK) edges <= edges + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t_start = 0;
  int early_done = 0;

  logic [W-1:0] exp_mem [MAX_POINTS][MAX_FEAT+1];
  logic [W-1:0] words_q [$];
  logic [W-1:0] words_a [$];
  bit           bit_q [$];

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic void gen_words(input int f, input int np);
    words_q.delete();
    for (int k = 0; k < np * (f + 1); k++) words_q.push_back(W'($urandom));
  endfunction

  // Word k of a load lands in point k/(f+1), slot f - k%(f+1).
  function automatic void commit(input int f, input int nw);
    for (int k = 0; k < nw; k++) exp_mem[k / (f + 1)][f - (k % (f + 1))] = words_q[k];
  endfunction

  function automatic logic [W-1:0] word_sum();
    logic [W-1:0] s = '0;
    foreach (words_q[k]) s = s + words_q[k];
    return s;
  endfunction

  function automatic void build_bits(input int with_ck, input logic [W-1:0] ck);
    logic [W-1:0] w;
    bit_q.delete();
    foreach (words_q[k]) begin
      w = words_q[k];
      for (int b = 0; b < W; b++) bit_q.push_back(w[b]);
    end
    if (with_ck != 0) for (int b = 0; b < W; b++) bit_q.push_back(ck[b]);
  endfunction

  task automatic start_load(input int f, input int np);
    feat = FW'(f);
    data_points = PT_W'(np);
    START = 1'b1;
    tick();
    t_start = edges;
    START = 1'b0;
    early_done = 0;
  endtask

  task automatic send_bits(input int limit, input bit gaps, output int idle);
    idle = 0;
    for (int i = 0; i < limit && bit_q.size() > 0; i++) begin
      if (LOAD_DONE === 1'b1) early_done++;
      S = bit_q.pop_front();
      S_VALID = 1'b1;
      tick();
      if (gaps && ((i + 1) % 5 == 0) && (i + 1 < limit) && (bit_q.size() > 0)) begin
        S_VALID = 1'b0;
        repeat (3) tick();
        idle += 3;
      end
    end
    S_VALID = 1'b0;
  endtask

  // rise = first sampling edge (relative to the START edge) that sees LOAD_DONE high; -1 on timeout.
  task automatic wait_done(output int rise);
    int guard = 0;
    while (LOAD_DONE !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    rise = (LOAD_DONE === 1'b1) ? (edges + 1 - t_start) : -1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_cmp++; if (RD_DATA !== '0)      begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", RD_DATA); end
    n_cmp++; if (LOAD_BUSY !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", LOAD_BUSY); end
    n_cmp++; if (LOAD_DONE !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", LOAD_DONE); end
    n_cmp++; if (CFG_ERR !== 1'b0)    begin n_bad++; $display("FAIL reset_cfg_err: got %b want 0", CFG_ERR); end
    n_cmp++; if (CHK_ERR !== 1'b0)    begin n_bad++; $display("FAIL reset_chk_err: got %b want 0", CHK_ERR); end
    n_cmp++; if (WORDS_LOADED !== '0) begin n_bad++; $display("FAIL reset_words: got %0d want 0", WORDS_LOADED); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int idle, rise;
    gen_words(11, 4);
    words_a = words_q;
    build_bits(CK, word_sum());
    start_load(11, 4);
    n_cmp++; if (LOAD_BUSY !== 1'b1) begin n_bad++; $display("FAIL cont_busy_after_start: got %b want 1", LOAD_BUSY); end
    send_bits(100000, 1'b0, idle);
    wait_done(rise);
    n_cmp++; if (rise != 768 + CK * W + 1 || early_done != 0)
      begin n_bad++; $display("FAIL cont_done_edge: got +%0d (early %0d) want +%0d", rise, early_done, 768 + CK * W + 1); end
    n_cmp++; if (WORDS_LOADED !== 16'd48) begin n_bad++; $display("FAIL cont_words: got %0d want 48", WORDS_LOADED); end
    n_cmp++; if (CHK_ERR !== 1'b0 || CFG_ERR !== 1'b0)
      begin n_bad++; $display("FAIL cont_err_flags: got chk=%b cfg=%b want 0 0", CHK_ERR, CFG_ERR); end
    commit(11, 48);
  endtask

  task automatic test_readback(input int f, input int np, input string tag);
    for (int p = 0; p < np; p++) begin
      for (int fi = 0; fi <= f; fi++) begin
        RD_PT = PT_W'(p);
        RD_F = FW'(fi);
        tick();
        n_cmp++;
        if (RD_DATA !== exp_mem[p][fi]) begin
          n_bad++;
          $display("FAIL %s_read[%0d][%0d]: got %h want %h", tag, p, fi, RD_DATA, exp_mem[p][fi]);
        end
      end
    end
    RD_PT = PT_W'(MAX_POINTS);
    tick();
    n_cmp++; if (RD_DATA !== '0) begin n_bad++; $display("FAIL %s_read_oob: got %h want 0", tag, RD_DATA); end
  endtask

  task automatic test_rst_mid_load();
    int idle, rise;
    gen_words(11, 4);
    build_bits(0, '0);
    start_load(11, 4);
    send_bits(100, 1'b0, idle);
    n_cmp++; if (WORDS_LOADED !== 16'd6) begin n_bad++; $display("FAIL midrst_words_before: got %0d want 6", WORDS_LOADED); end
    commit(11, 6);
    RST = 1'b1;
    tick();
    n_cmp++; if (LOAD_BUSY !== 1'b0 || LOAD_DONE !== 1'b0 || WORDS_LOADED !== '0 || RD_DATA !== '0)
      begin n_bad++; $display("FAIL midrst_cleared: got busy=%b done=%b words=%0d rd=%h want 0 0 0 0", LOAD_BUSY, LOAD_DONE, WORDS_LOADED, RD_DATA); end
    RST = 1'b0;
    tick();
    gen_words(3, 2);
    build_bits(CK, word_sum());
    start_load(3, 2);
    n_cmp++; if (WORDS_LOADED !== '0) begin n_bad++; $display("FAIL midrst_words_restart: got %0d want 0", WORDS_LOADED); end
    send_bits(100000, 1'b0, idle);
    wait_done(rise);
    n_cmp++; if (rise != 128 + CK * W + 1 || early_done != 0)
      begin n_bad++; $display("FAIL midrst_done_edge: got +%0d want +%0d", rise, 128 + CK * W + 1); end
    n_cmp++; if (WORDS_LOADED !== 16'd8) begin n_bad++; $display("FAIL midrst_words_after: got %0d want 8", WORDS_LOADED); end
    commit(3, 8);
  endtask

  task automatic test_gapped();
    int idle, rise;
    words_q = words_a;
    build_bits(CK, word_sum());
    start_load(11, 4);
    send_bits(100000, 1'b1, idle);
    wait_done(rise);
    n_cmp++; if (rise != 768 + CK * W + 1 + idle || early_done != 0)
      begin n_bad++; $display("FAIL gap_done_edge: got +%0d want +%0d (idle %0d)", rise, 768 + CK * W + 1 + idle, idle); end
    n_cmp++; if (WORDS_LOADED !== 16'd48) begin n_bad++; $display("FAIL gap_words: got %0d want 48", WORDS_LOADED); end
    commit(11, 48);
  endtask

  task automatic test_zero_points();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    start_load(5, 0);
    n_cmp++; if (LOAD_DONE !== 1'b1 || CFG_ERR !== 1'b0 || LOAD_BUSY !== 1'b0)
      begin n_bad++; $display("FAIL zero_pts: got done=%b cfg=%b busy=%b want 1 0 0", LOAD_DONE, CFG_ERR, LOAD_BUSY); end
  endtask

  task automatic test_cfg_err();
    RD_PT = '0;
    RD_F = FW'(11);
    start_load(11, 65);
    n_cmp++; if (CFG_ERR !== 1'b1 || LOAD_DONE !== 1'b1 || LOAD_BUSY !== 1'b0)
      begin n_bad++; $display("FAIL cfg_err_flags: got cfg=%b done=%b busy=%b want 1 1 0", CFG_ERR, LOAD_DONE, LOAD_BUSY); end
    for (int i = 0; i < W; i++) begin
      S = 1'($urandom);
      S_VALID = 1'b1;
      tick();
    end
    S_VALID = 1'b0;
    n_cmp++; if (WORDS_LOADED !== '0) begin n_bad++; $display("FAIL cfg_err_words: got %0d want 0", WORDS_LOADED); end
    n_cmp++; if (RD_DATA !== exp_mem[0][11]) begin n_bad++; $display("FAIL cfg_err_nowrite: got %h want %h", RD_DATA, exp_mem[0][11]); end
    start_load(11, 0);
    n_cmp++; if (CFG_ERR !== 1'b0 || LOAD_DONE !== 1'b1)
      begin n_bad++; $display("FAIL cfg_err_rearm: got cfg=%b done=%b want 0 1", CFG_ERR, LOAD_DONE); end
  endtask

  task automatic test_collision();
    int idle, rise;
    logic [W-1:0] old_val;
    gen_words(0, 2);
    old_val = exp_mem[1][0];
    build_bits(CK, word_sum());
    RD_PT = PT_W'(1);
    RD_F = '0;
    start_load(0, 2);
    send_bits(2 * W, 1'b0, idle);
    n_cmp++; if (RD_DATA !== old_val) begin n_bad++; $display("FAIL rw_same_cycle_old: got %h want %h", RD_DATA, old_val); end
    tick();
    n_cmp++; if (RD_DATA !== words_q[1]) begin n_bad++; $display("FAIL rw_next_read_new: got %h want %h", RD_DATA, words_q[1]); end
    send_bits(100000, 1'b0, idle);
    wait_done(rise);
    n_cmp++; if (rise < 0) begin n_bad++; $display("FAIL rw_done_timeout: got LOAD_DONE=%b want 1", LOAD_DONE); end
    commit(0, 2);
  endtask

  task automatic test_checksum();
    int idle, rise;
    logic [W-1:0] ck_tab [3];
    logic         err_tab [3];
    ck_tab  = '{16'h0001, 16'h0002, 16'h0001};
    err_tab = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < (CK != 0 ? 3 : 1); i++) begin
      words_q = '{16'hFFFF, 16'h0002};
      build_bits(CK, ck_tab[i]);
      start_load(0, 2);
      send_bits(100000, 1'b0, idle);
      wait_done(rise);
      n_cmp++; if (rise != 2 * W + CK * W + 1 || early_done != 0)
        begin n_bad++; $display("FAIL ck%0d_done_edge: got +%0d want +%0d", i, rise, 2 * W + CK * W + 1); end
      n_cmp++; if (CHK_ERR !== (CK != 0 ? err_tab[i] : 1'b0))
        begin n_bad++; $display("FAIL ck%0d_chk_err: got %b want %b", i, CHK_ERR, (CK != 0 ? err_tab[i] : 1'b0)); end
      commit(0, 2);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_readback(11, 4, "cont");
    test_rst_mid_load();
    test_readback(3, 2, "midrst");
    test_gapped();
    test_readback(11, 4, "gap");
    test_zero_points();
    test_cfg_err();
    test_collision();
    test_checksum();
    test_readback(0, 2, "ck");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
